// File: rtl/pin_pkg.sv
// Shared types and sizing helpers for the PIN-entry checker.
package pin_pkg;

  localparam int unsigned ST_W = 3;

  typedef enum logic [ST_W-1:0] {
    ST_ENTRY    = 3'd0,
    ST_CHECK    = 3'd1,
    ST_SHOW_OK  = 3'd2,
    ST_SHOW_BAD = 3'd3,
    ST_LOCKOUT  = 3'd4
  } state_e;

  // Bits needed to hold any count in 0..n (never less than one bit).
  function automatic int unsigned cnt_w(input int unsigned n);
    int unsigned w;
    w = unsigned'($clog2(n + 1));
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pin_hold_timer.sv
// Reloadable down-counter; done marks the last cycle of a loaded interval.
module pin_hold_timer
  import pin_pkg::*;
#(
  parameter int unsigned MAX_CYCLES = 32,
  localparam int unsigned W = cnt_w(MAX_CYCLES)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] cycles,
  output logic         done
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = cycles;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == W'(1));

endmodule

// File: rtl/pin_verifier.sv
// PIN-entry checker: shifts in digits, compares against PASSKEY, shows a timed
// result and enforces a timed lockout after MAX_TRIES consecutive misses.
module pin_verifier
  import pin_pkg::*;
#(
  parameter int unsigned                     DIGIT_W     = 2,
  parameter int unsigned                     PIN_LEN     = 4,
  parameter logic [DIGIT_W*PIN_LEN-1:0]      PASSKEY     = 8'h9C,
  parameter int unsigned                     MAX_TRIES   = 3,
  parameter int unsigned                     HOLD_CYCLES = 8,
  parameter int unsigned                     LOCK_CYCLES = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [DIGIT_W-1:0]               digit,
  input  logic                             submit,
  input  logic                             clear,
  output logic                             waiting,
  output logic [$clog2(PIN_LEN+1)-1:0]     digits_entered,
  output logic                             correct,
  output logic                             incorrect,
  output logic                             locked,
  output logic                             bug
);

  localparam int unsigned ENTRY_W = DIGIT_W * PIN_LEN;
  localparam int unsigned CNT_W   = $clog2(PIN_LEN + 1);
  localparam int unsigned FAIL_W  = cnt_w(MAX_TRIES);
  localparam int unsigned TMR_MAX = max_u(HOLD_CYCLES, LOCK_CYCLES);
  localparam int unsigned TMR_W   = cnt_w(TMR_MAX);

  localparam logic [CNT_W-1:0]  LAST_C = CNT_W'(PIN_LEN - 1);
  localparam logic [FAIL_W-1:0] MAX_F  = FAIL_W'(MAX_TRIES);
  localparam logic [TMR_W-1:0]  HOLD_C = TMR_W'(HOLD_CYCLES);
  localparam logic [TMR_W-1:0]  LOCK_C = TMR_W'(LOCK_CYCLES);

  state_e              state_q, state_d;
  logic [ENTRY_W-1:0]  entry_q, entry_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [FAIL_W-1:0]   fail_q, fail_d;
  logic                bug_q, bug_d;
  logic                waiting_q, waiting_d;
  logic                correct_q, correct_d;
  logic                incorrect_q, incorrect_d;
  logic                locked_q, locked_d;

  logic                tmr_load;
  logic [TMR_W-1:0]    tmr_cycles;
  logic                tmr_done;
  logic                illegal;

  // One countdown serves both the result display and the lockout.
  pin_hold_timer #(
    .MAX_CYCLES(TMR_MAX)
  ) u_timer (
    .clk    (clk),
    .reset  (reset | illegal),
    .load   (tmr_load),
    .cycles (tmr_cycles),
    .done   (tmr_done)
  );

  always_comb begin
    state_d    = state_q;
    entry_d    = entry_q;
    cnt_d      = cnt_q;
    fail_d     = fail_q;
    bug_d      = bug_q;
    tmr_load   = 1'b0;
    tmr_cycles = HOLD_C;
    illegal    = 1'b0;

    case (state_q)
      ST_ENTRY: begin
        if (clear) begin
          entry_d = '0;
          cnt_d   = '0;
        end else if (submit) begin
          entry_d = (entry_q << DIGIT_W) | ENTRY_W'(digit);
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST_C) begin
            state_d = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        tmr_load   = 1'b1;
        tmr_cycles = HOLD_C;
        if (entry_q == PASSKEY) begin
          state_d = ST_SHOW_OK;
          fail_d  = '0;
        end else begin
          state_d = ST_SHOW_BAD;
          fail_d  = (fail_q == MAX_F) ? fail_q : fail_q + 1'b1;
        end
      end
      ST_SHOW_OK: begin
        if (tmr_done) begin
          state_d = ST_ENTRY;
          entry_d = '0;
          cnt_d   = '0;
        end
      end
      ST_SHOW_BAD: begin
        if (tmr_done) begin
          if (fail_q == MAX_F) begin
            state_d    = ST_LOCKOUT;
            tmr_load   = 1'b1;
            tmr_cycles = LOCK_C;
          end else begin
            state_d = ST_ENTRY;
            entry_d = '0;
            cnt_d   = '0;
          end
        end
      end
      ST_LOCKOUT: begin
        if (tmr_done) begin
          state_d = ST_ENTRY;
          fail_d  = '0;
          entry_d = '0;
          cnt_d   = '0;
        end
      end
      default: begin
        illegal = 1'b1;
        bug_d   = 1'b1;
        state_d = ST_ENTRY;
        entry_d = '0;
        cnt_d   = '0;
        fail_d  = '0;
      end
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    waiting_d   = (state_d == ST_ENTRY);
    correct_d   = (state_d == ST_SHOW_OK);
    incorrect_d = (state_d == ST_SHOW_BAD);
    locked_d    = (state_d == ST_LOCKOUT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_ENTRY;
      entry_q     <= '0;
      cnt_q       <= '0;
      fail_q      <= '0;
      bug_q       <= 1'b0;
      waiting_q   <= 1'b1;
      correct_q   <= 1'b0;
      incorrect_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      entry_q     <= entry_d;
      cnt_q       <= cnt_d;
      fail_q      <= fail_d;
      bug_q       <= bug_d;
      waiting_q   <= waiting_d;
      correct_q   <= correct_d;
      incorrect_q <= incorrect_d;
      locked_q    <= locked_d;
    end
  end

  assign waiting        = waiting_q;
  assign digits_entered = cnt_q;
  assign correct        = correct_q;
  assign incorrect      = incorrect_q;
  assign locked         = locked_q;
  assign bug            = bug_q;

endmodule

// File: tb/tb_pin_verifier.sv
// Directed bench for pin_verifier: default build plus a 4-bit x 6-digit build.
module tb_pin_verifier;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, submit, clear;
  logic [1:0] digit;
  logic       waiting, correct, incorrect, locked, bug;
  logic [2:0] digits_entered;

  logic       w_reset, w_submit, w_clear;
  logic [3:0] w_digit;
  logic       w_waiting, w_correct, w_incorrect, w_locked, w_bug;
  logic [2:0] w_digits;

  int checks = 0;
  int passes = 0;

  localparam logic [7:0] RST_VEC = 8'b1000_0000;

  pin_verifier u_dut (
    .clk(clk), .reset(reset), .digit(digit), .submit(submit), .clear(clear),
    .waiting(waiting), .digits_entered(digits_entered), .correct(correct),
    .incorrect(incorrect), .locked(locked), .bug(bug)
  );

  pin_verifier #(
    .DIGIT_W(4), .PIN_LEN(6), .PASSKEY(24'h5A3C71),
    .MAX_TRIES(3), .HOLD_CYCLES(8), .LOCK_CYCLES(32)
  ) u_wide (
    .clk(clk), .reset(w_reset), .digit(w_digit), .submit(w_submit), .clear(w_clear),
    .waiting(w_waiting), .digits_entered(w_digits), .correct(w_correct),
    .incorrect(w_incorrect), .locked(w_locked), .bug(w_bug)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic put_digit(input logic [1:0] d);
    digit  = d;
    submit = 1'b1;
    tick();
    submit = 1'b0;
  endtask

  task automatic enter_pin(input logic [7:0] pin);
    for (int i = 3; i >= 0; i--) put_digit(pin[2*i +: 2]);
  endtask

  // Observes one result sequence until waiting returns (bounded); optional submit spam.
  task automatic run_result(input logic spam, output int n_ok, output int n_bad,
                            output int n_lock, output int first_ok, output int first_bad,
                            output int first_lock, output int total, output int excl);
    n_ok = 0; n_bad = 0; n_lock = 0; first_ok = 0; first_bad = 0; first_lock = 0;
    total = 0; excl = 0;
    for (int i = 1; i <= 200; i++) begin
      if (spam) begin
        submit = 1'b1;
        digit  = i[1:0];
      end
      tick();
      if (correct)   begin n_ok++;   if (first_ok == 0)   first_ok = i;   end
      if (incorrect) begin n_bad++;  if (first_bad == 0)  first_bad = i;  end
      if (locked)    begin n_lock++; if (first_lock == 0) first_lock = i; end
      if (int'(correct) + int'(incorrect) + int'(locked) + int'(waiting) != 1) excl++;
      if (waiting) begin
        total = i;
        break;
      end
    end
    submit = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; submit = 1'b0; clear = 1'b0; digit = '0;
    w_reset = 1'b1; w_submit = 1'b0; w_clear = 1'b0; w_digit = '0;
    tick(); tick();
    checks++;
    if ({waiting, digits_entered, correct, incorrect, locked, bug} !== RST_VEC)
      $display("FAIL reset_vals got=%b exp=%b",
               {waiting, digits_entered, correct, incorrect, locked, bug}, RST_VEC);
    else passes++;
    checks++;
    if ({w_waiting, w_digits, w_correct, w_incorrect, w_locked, w_bug} !== RST_VEC)
      $display("FAIL wide_reset_vals got=%b exp=%b",
               {w_waiting, w_digits, w_correct, w_incorrect, w_locked, w_bug}, RST_VEC);
    else passes++;
    reset = 1'b0; w_reset = 1'b0;
  endtask

  task automatic test_correct();
    int n_ok, n_bad, n_lock, f_ok, f_bad, f_lock, total, excl;
    enter_pin(8'h9C);
    checks++;
    if ({waiting, digits_entered} !== 4'b0100)
      $display("FAIL ok_after_last got=%b exp=0100", {waiting, digits_entered});
    else passes++;
    run_result(1'b0, n_ok, n_bad, n_lock, f_ok, f_bad, f_lock, total, excl);
    checks++;
    if (n_ok !== 8 || f_ok !== 1) $display("FAIL ok_pulse got=%0d@%0d exp=8@1", n_ok, f_ok);
    else passes++;
    checks++;
    if (n_bad + n_lock !== 0 || total !== 9 || excl !== 0)
      $display("FAIL ok_seq got bad+lock=%0d total=%0d excl=%0d exp 0/9/0",
               n_bad + n_lock, total, excl);
    else passes++;
    checks++;
    if (digits_entered !== 3'd0) $display("FAIL ok_cnt_clr got=%0d exp=0", digits_entered);
    else passes++;
  endtask

  task automatic test_wrong();
    int n_ok, n_bad, n_lock, f_ok, f_bad, f_lock, total, excl;
    enter_pin(8'h9D);
    run_result(1'b0, n_ok, n_bad, n_lock, f_ok, f_bad, f_lock, total, excl);
    checks++;
    if (n_bad !== 8 || f_bad !== 1 || n_ok !== 0)
      $display("FAIL bad_pulse got=%0d@%0d ok=%0d exp=8@1 ok=0", n_bad, f_bad, n_ok);
    else passes++;
    checks++;
    if (n_lock !== 0 || total !== 9 || excl !== 0)
      $display("FAIL bad_nolock got lock=%0d total=%0d excl=%0d exp 0/9/0", n_lock, total, excl);
    else passes++;
  endtask

  task automatic test_lockout();
    int n_ok, n_bad, n_lock, f_ok, f_bad, f_lock, total, excl;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      enter_pin(8'h9D);
      run_result(1'b0, n_ok, n_bad, n_lock, f_ok, f_bad, f_lock, total, excl);
    end
    checks++;
    if (n_lock !== 0 || total !== 9) $display("FAIL lock_early got lock=%0d total=%0d exp 0/9", n_lock, total);
    else passes++;
    enter_pin(8'h9D);
    run_result(1'b1, n_ok, n_bad, n_lock, f_ok, f_bad, f_lock, total, excl);
    checks++;
    if (n_bad !== 8 || n_lock !== 32 || f_lock !== 9)
      $display("FAIL lock_len got bad=%0d lock=%0d@%0d exp 8 32@9", n_bad, n_lock, f_lock);
    else passes++;
    checks++;
    if (total !== 41 || excl !== 0) $display("FAIL lock_seq got total=%0d excl=%0d exp 41/0", total, excl);
    else passes++;
    checks++;
    if (digits_entered !== 3'd0) $display("FAIL lock_ignores_submit got=%0d exp=0", digits_entered);
    else passes++;
    enter_pin(8'h9C);
    run_result(1'b0, n_ok, n_bad, n_lock, f_ok, f_bad, f_lock, total, excl);
    checks++;
    if (n_ok !== 8 || n_bad !== 0) $display("FAIL lock_then_ok got ok=%0d bad=%0d exp 8/0", n_ok, n_bad);
    else passes++;
  endtask

  task automatic test_counter_reset();
    int n_ok, n_bad, n_lock, f_ok, f_bad, f_lock, total, excl;
    logic [7:0] seq [5];
    seq = '{8'h9D, 8'h1C, 8'h9C, 8'h9D, 8'h00};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      enter_pin(seq[k]);
      run_result(1'b0, n_ok, n_bad, n_lock, f_ok, f_bad, f_lock, total, excl);
    end
    checks++;
    if (n_lock !== 0 || n_bad !== 8 || total !== 9)
      $display("FAIL cnt_reset_on_pass got lock=%0d bad=%0d total=%0d exp 0/8/9", n_lock, n_bad, total);
    else passes++;
    enter_pin(8'hFF);
    run_result(1'b0, n_ok, n_bad, n_lock, f_ok, f_bad, f_lock, total, excl);
    checks++;
    if (n_lock !== 32) $display("FAIL cnt_third_locks got lock=%0d exp=32", n_lock);
    else passes++;
  endtask

  task automatic test_clear();
    int n_ok, n_bad, n_lock, f_ok, f_bad, f_lock, total, excl;
    do_reset();
    put_digit(2'd2); put_digit(2'd1);
    checks++;
    if (digits_entered !== 3'd2) $display("FAIL clr_partial got=%0d exp=2", digits_entered);
    else passes++;
    clear = 1'b1; tick(); clear = 1'b0;
    checks++;
    if (digits_entered !== 3'd0) $display("FAIL clr_zero got=%0d exp=0", digits_entered);
    else passes++;
    put_digit(2'd2);
    clear = 1'b1; submit = 1'b1; digit = 2'd1;
    tick();
    clear = 1'b0; submit = 1'b0;
    checks++;
    if (digits_entered !== 3'd0) $display("FAIL clr_wins got=%0d exp=0", digits_entered);
    else passes++;
    enter_pin(8'h9C);
    run_result(1'b0, n_ok, n_bad, n_lock, f_ok, f_bad, f_lock, total, excl);
    checks++;
    if (n_ok !== 8 || n_bad !== 0) $display("FAIL clr_then_ok got ok=%0d bad=%0d exp 8/0", n_ok, n_bad);
    else passes++;
  endtask

  task automatic test_reset_mid();
    int n_ok, n_bad, n_lock, f_ok, f_bad, f_lock, total, excl;
    do_reset();
    put_digit(2'd2); put_digit(2'd1);
    do_reset();
    checks++;
    if ({waiting, digits_entered, correct, incorrect, locked, bug} !== RST_VEC)
      $display("FAIL rst_mid_entry got=%b exp=%b",
               {waiting, digits_entered, correct, incorrect, locked, bug}, RST_VEC);
    else passes++;
    enter_pin(8'h9D);
    repeat (3) tick();
    do_reset();
    checks++;
    if ({waiting, digits_entered, correct, incorrect, locked, bug} !== RST_VEC)
      $display("FAIL rst_mid_show got=%b exp=%b",
               {waiting, digits_entered, correct, incorrect, locked, bug}, RST_VEC);
    else passes++;
    for (int k = 0; k < 2; k++) begin
      enter_pin(8'h9D);
      run_result(1'b0, n_ok, n_bad, n_lock, f_ok, f_bad, f_lock, total, excl);
    end
    enter_pin(8'h9D);
    repeat (14) tick();
    checks++;
    if (locked !== 1'b1) $display("FAIL rst_pre_lock got=%b exp=1", locked);
    else passes++;
    do_reset();
    checks++;
    if ({waiting, digits_entered, correct, incorrect, locked, bug} !== RST_VEC)
      $display("FAIL rst_mid_lock got=%b exp=%b",
               {waiting, digits_entered, correct, incorrect, locked, bug}, RST_VEC);
    else passes++;
    enter_pin(8'h9C);
    run_result(1'b0, n_ok, n_bad, n_lock, f_ok, f_bad, f_lock, total, excl);
    checks++;
    if (n_ok !== 8) $display("FAIL rst_then_ok got=%0d exp=8", n_ok);
    else passes++;
  endtask

  task automatic test_wide();
    logic [23:0] pins [2];
    int hits, total;
    pins = '{24'h5A3C71, 24'h5A3C70};
    for (int p = 0; p < 2; p++) begin
      for (int i = 5; i >= 0; i--) begin
        w_digit  = pins[p][4*i +: 4];
        w_submit = 1'b1;
        tick();
        w_submit = 1'b0;
      end
      checks++;
      if ({w_waiting, w_digits} !== 4'b0110)
        $display("FAIL wide_after_last got=%b exp=0110", {w_waiting, w_digits});
      else passes++;
      hits = 0; total = 0;
      for (int i = 1; i <= 50; i++) begin
        tick();
        if ((p == 0) ? w_correct : w_incorrect) hits++;
        if (w_waiting) begin total = i; break; end
      end
      checks++;
      if (hits !== 8 || total !== 9)
        $display("FAIL wide_result%0d got hits=%0d total=%0d exp 8/9", p, hits, total);
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_correct();
    test_wrong();
    test_lockout();
    test_counter_reset();
    test_clear();
    test_reset_mid();
    test_wide();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
